// File: rtl/riscv_pkg.sv
// riscv_pkg: RV32I opcodes, XLEN and the fetch entry type shared by fetch and controller
package riscv_pkg;
  localparam int XLEN = 32;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;
  function automatic logic [6:0] opcode_of(input logic [XLEN-1:0] instr);
    return instr[6:0];
  endfunction
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous FIFO of fetch entries with a single-cycle flush
module fetch_fifo
  import riscv_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  fetch_entry_t             wdata,
  input  logic                     pop,
  output fetch_entry_t             rdata,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  fetch_entry_t mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  assign rdata = mem[rd_ptr];
  assign empty = count == '0;
  always_ff @(posedge clk)
    if (push && !reset && !flush) mem[wr_ptr] <= wdata;
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: PC, credit-limited imem requests and response FIFO feeding decode
// FETCH_BYPASS_EN presents a response on if_* in its arrival cycle when the FIFO is empty.
module instr_fetch
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int              DEPTH    = 2
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_instr,
  output logic [6:0]      if_opcode
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);
  logic [XLEN-1:0] pc, redir_pc;
  logic [XLEN-1:0] addr_q [DEPTH];
  logic [AW-1:0] aq_wr, aq_rd;
  logic [CW-1:0] outstanding, drop_cnt, count;
  logic accept, dropping, fifo_empty, push, pop, avail;
  fetch_entry_t head, rsp_entry, out_entry;
  assign redir_pc = redirect_pc & ~32'h3;
  assign dropping = drop_cnt != '0;
  assign imem_req_valid = !reset && ({1'b0, outstanding} + {1'b0, count}) < DEPTH_C;
  assign imem_req_addr = reset ? '0 : redirect_valid ? redir_pc : pc;
  assign accept = imem_req_valid && imem_req_ready;
  assign rsp_entry = '{pc: addr_q[aq_rd], instr: imem_rsp_data};
`ifdef FETCH_BYPASS_EN
  logic bypass;
  assign bypass = fifo_empty && !dropping && !redirect_valid && imem_rsp_valid;
  assign push = imem_rsp_valid && !redirect_valid && !dropping && !(bypass && if_ready);
  assign out_entry = fifo_empty ? rsp_entry : head;
  assign avail = !fifo_empty || bypass;
`else
  assign push = imem_rsp_valid && !redirect_valid && !dropping;
  assign out_entry = head;
  assign avail = !fifo_empty;
`endif
  assign if_valid = !reset && !redirect_valid && avail;
  assign pop = if_valid && if_ready && !fifo_empty;
  assign if_pc = if_valid ? out_entry.pc : '0;
  assign if_instr = if_valid ? out_entry.instr : '0;
  assign if_opcode = opcode_of(if_instr);
  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (redirect_valid),
    .push  (push),
    .wdata (rsp_entry),
    .pop   (pop),
    .rdata (head),
    .empty (fifo_empty),
    .count (count)
  );
  always_ff @(posedge clk)
    if (accept) addr_q[aq_wr] <= imem_req_addr;
  // every request outstanding at a redirect is wrong-path, minus the one answered now
  always_ff @(posedge clk) begin
    if (reset) begin
      pc          <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
      aq_wr       <= '0;
      aq_rd       <= '0;
    end else begin
      pc          <= accept ? imem_req_addr + 32'd4 : redirect_valid ? redir_pc : pc;
      outstanding <= outstanding + CW'(accept) - CW'(imem_rsp_valid);
      drop_cnt    <= redirect_valid ? outstanding - CW'(imem_rsp_valid) :
                     (imem_rsp_valid && dropping) ? drop_cnt - CW'(1) : drop_cnt;
      aq_wr       <= accept ? aq_wr + AW'(1) : aq_wr;
      aq_rd       <= imem_rsp_valid ? aq_rd + AW'(1) : aq_rd;
    end
  end
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed, table and random checks of instr_fetch against a path/epoch model
module tb_instr_fetch;
  localparam int DEPTH = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
`ifdef FETCH_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic clk = 1'b0, reset = 1'b1;
  logic imem_req_valid, imem_req_ready = 1'b0, imem_rsp_valid = 1'b0;
  logic [31:0] imem_req_addr, imem_rsp_data = '0, redirect_pc = '0, if_pc, if_instr;
  logic redirect_valid = 1'b0, if_valid, if_ready = 1'b0;
  logic [6:0] if_opcode;
  instr_fetch #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc), .if_instr(if_instr), .if_opcode(if_opcode)
  );
  always #5 clk = ~clk;

  typedef struct {logic [31:0] addr; int due; int ep;} mreq_t;
  typedef struct {logic [31:0] rpc; logic [31:0] exp_addr;} vec_t;
  mreq_t mq[$];
  logic [31:0] path[$];
  int n_cmp = 0, n_bad = 0, cyc = 0, buffered = 0, epoch = 0, last_due = 0;
  int lat_min = 1, lat_max = 1;
  logic [31:0] mpc = RESET_PC, drv_rpc = '0;
  logic drv_reset = 1'b1, drv_req_ready = 1'b1, drv_if_ready = 1'b1, drv_redirect = 1'b0;

  function automatic logic [31:0] word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0013;
  endfunction

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", n, act, exp, cyc);
    end
  endtask

  // one clock: drive at negedge, check against the model, advance the model
  task automatic tick();
    logic rsp, rsp_cur, exp_rv, exp_ifv;
    logic [31:0] rp, ea;
    int lat;
    @(negedge clk);
    rsp = !drv_reset && mq.size() > 0 && mq[0].due <= cyc;
    reset = drv_reset;
    imem_req_ready = drv_req_ready;
    if_ready = drv_if_ready;
    redirect_valid = drv_redirect;
    redirect_pc = drv_rpc;
    imem_rsp_valid = rsp;
    imem_rsp_data = rsp ? word(mq[0].addr) : $urandom;
    #1;
    if (drv_reset) begin
      chk("rst_req_valid", 32'(imem_req_valid), 0);
      chk("rst_req_addr", imem_req_addr, 0);
      chk("rst_if_valid", 32'(if_valid), 0);
      chk("rst_if_zero", if_pc | if_instr | 32'(if_opcode), 0);
      mq.delete(); path.delete();
      buffered = 0; mpc = RESET_PC; last_due = 0;
    end else begin
      rp = drv_rpc & ~32'h3;
      exp_rv = (mq.size() + buffered) < DEPTH;
      ea = drv_redirect ? rp : mpc;
      chk("req_valid", 32'(imem_req_valid), 32'(exp_rv));
      chk("req_addr", imem_req_addr, ea);
      rsp_cur = rsp && mq[0].ep == epoch && !drv_redirect;
      exp_ifv = !drv_redirect && (buffered > 0 || (BYP && rsp_cur));
      chk("if_valid", 32'(if_valid), 32'(exp_ifv));
      if (exp_ifv) begin
        chk("if_pc", if_pc, path[0]);
        chk("if_instr", if_instr, word(path[0]));
        chk("if_opcode", 32'(if_opcode), 32'(word(path[0]) & 32'h7F));
      end else chk("if_zero", if_pc | if_instr | 32'(if_opcode), 0);
      if (drv_redirect) begin
        epoch++; path.delete(); buffered = 0;
      end else begin
        if (rsp_cur) buffered++;
        if (exp_ifv && drv_if_ready) begin
          buffered--; void'(path.pop_front());
        end
      end
      if (rsp) void'(mq.pop_front());
      if (exp_rv && drv_req_ready) begin
        lat = $urandom_range(lat_max, lat_min);
        last_due = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
        mq.push_back('{addr: ea, due: last_due, ep: epoch});
        path.push_back(ea);
        mpc = ea + 32'd4;
      end else if (drv_redirect) mpc = rp;
    end
    cyc++;
  endtask

  initial begin
    vec_t vt[5];
    bit got;
    vt[0] = '{32'h0000_0203, 32'h0000_0200};
    vt[1] = '{32'h0000_0100, 32'h0000_0100};
    vt[2] = '{32'hFFFF_FFFF, 32'hFFFF_FFFC};
    vt[3] = '{32'h1234_5679, 32'h1234_5678};
    vt[4] = '{32'h8000_0002, 32'h8000_0000};
    // reset release with 1-cycle memory
    repeat (3) tick();
    drv_reset = 1'b0;
    tick();
    chk("first_req_valid", 32'(imem_req_valid), 1);
    chk("first_req_addr", imem_req_addr, RESET_PC);
    tick();
    chk("c1_if_valid", 32'(if_valid), 32'(BYP));
    tick();
    chk("c2_if_valid", 32'(if_valid), 1);
    chk("c2_if_pc", if_pc, BYP ? RESET_PC + 32'd4 : RESET_PC);
    repeat (10) tick();
    // decode stall: credits must block further requests
    drv_if_ready = 1'b0;
    repeat (5) tick();
    chk("stall_req_valid", 32'(imem_req_valid), 0);
    drv_if_ready = 1'b1;
    repeat (10) tick();
    // redirect alignment table
    foreach (vt[i]) begin
      drv_redirect = 1'b1; drv_rpc = vt[i].rpc;
      tick();
      chk("tbl_req_addr", imem_req_addr, vt[i].exp_addr);
      chk("tbl_if_valid", 32'(if_valid), 0);
      drv_redirect = 1'b0;
      repeat (4) tick();
    end
    // redirect with two requests in flight
    lat_min = 3; lat_max = 3; got = 0;
    for (int k = 0; k < 20 && !got; k++) begin
      tick();
      got = mq.size() == 2;
    end
    chk("inflight_reached", 32'(got), 1);
    drv_redirect = 1'b1; drv_rpc = 32'h100;
    tick();
    chk("redir_req_addr", imem_req_addr, 32'h100);
    drv_redirect = 1'b0; got = 0;
    for (int k = 0; k < 20 && !got; k++) begin
      tick();
      got = if_valid;
      if (got) chk("redir_first_pc", if_pc, 32'h100);
    end
    chk("redir_delivered", 32'(got), 1);
    // redirect colliding with a response and a pop
    lat_min = 1; lat_max = 1; got = 0;
    for (int k = 0; k < 20 && !got; k++) begin
      tick();
      got = buffered > 0 && mq.size() > 0 && mq[0].due <= cyc;
    end
    chk("collide_reached", 32'(got), 1);
    drv_redirect = 1'b1; drv_rpc = 32'h300;
    tick();
    chk("collide_if_valid", 32'(if_valid), 0);
    drv_redirect = 1'b0;
    tick();
    chk("flush_empty", 32'(if_valid && !(BYP && if_pc == 32'h300)), 0);
    repeat (6) tick();
    // reset with a full FIFO
    drv_if_ready = 1'b0; got = 0;
    for (int k = 0; k < 30 && !got; k++) begin
      tick();
      got = buffered == DEPTH;
    end
    chk("full_reached", 32'(got), 1);
    drv_reset = 1'b1;
    tick();
    drv_reset = 1'b0; drv_if_ready = 1'b1;
    tick();
    chk("post_rst_if_valid", 32'(if_valid), 0);
    chk("post_rst_req", imem_req_addr, RESET_PC);
    chk("post_rst_req_valid", 32'(imem_req_valid), 1);
    // random traffic against the model
    lat_min = 1; lat_max = 4;
    for (int k = 0; k < 4000; k++) begin
      drv_reset = $urandom_range(0, 249) == 0;
      drv_redirect = !drv_reset && !drv_redirect && $urandom_range(0, 19) == 0;
      drv_rpc = $urandom;
      drv_req_ready = $urandom_range(0, 3) != 0;
      drv_if_ready = $urandom_range(0, 2) != 0;
      tick();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
